// File: rtl/aes_out_block_scheduler.sv
// aes_out_block_scheduler
// Round-robin arbiter between two AES result producers sharing one 32-bit
// AXI-Stream output. A granted 128-bit block is captured and drained as
// NWORDS words, least-significant word first, with TLAST on the final word.
module aes_out_block_scheduler #(
   parameter int NWORDS = 4,
   parameter int WORD_W = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clear,
   input  logic                     src0_valid,
   input  logic [NWORDS*WORD_W-1:0] src0_data,
   output logic                     src0_ready,
   input  logic                     src1_valid,
   input  logic [NWORDS*WORD_W-1:0] src1_data,
   output logic                     src1_ready,
   output logic [WORD_W-1:0]        m_tdata,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic                     m_tlast,
   output logic                     m_tid,
   output logic                     busy
);

   localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NWORDS - 1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t                          state_q, state_d;
   logic [WIDX_W-1:0]               w_q;
   logic [NWORDS-1:0][WORD_W-1:0]   blk_q;
   logic                            tid_q;
   logic                            last_grant_q;

   logic grant;     // source that would win this cycle (0/1)
   logic req;       // any source offering a block
   logic hs;        // a source handshake happens this cycle
   logic drain;

   // Arbitration: a lone requester wins; on contention the source that did
   // not win last time is granted. clear blocks any handshake.
   always_comb begin
      req   = src0_valid || src1_valid;
      grant = (src0_valid && src1_valid) ? ~last_grant_q : src1_valid;
      hs    = (state_q == IDLE) && req && !clear;
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; clear overrides everything and returns to IDLE
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (req) state_d = DRAIN;
            DRAIN:   if (m_tready && (w_q == LAST_IDX)) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Block capture, word index and round-robin history
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         w_q          <= '0;
         blk_q        <= '0;
         tid_q        <= 1'b0;
         last_grant_q <= 1'b1;   // so src0 wins the first contention
      end else if (clear) begin
         w_q <= '0;
      end else if (hs) begin
         blk_q        <= grant ? src1_data : src0_data;
         tid_q        <= grant;
         last_grant_q <= grant;
         w_q          <= '0;
      end else if (state_q == DRAIN && m_tready) begin
         w_q <= (w_q == LAST_IDX) ? '0 : w_q + WIDX_W'(1);
      end
   end

   // Outputs; data is forced to zero outside DRAIN so a dropped block never leaks
   always_comb begin
      drain      = (state_q == DRAIN);
      src0_ready = hs && !grant;
      src1_ready = hs && grant;
      m_tvalid   = drain;
      m_tlast    = drain && (w_q == LAST_IDX);
      m_tdata    = drain ? blk_q[w_q] : '0;
      m_tid      = tid_q;
      busy       = drain;
   end

endmodule

// File: tb/tb_aes_out_block_scheduler.sv
// Directed bench for aes_out_block_scheduler. Inputs change on the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_aes_out_block_scheduler;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         clear = 1'b0;
   logic         src0_valid = 1'b0, src1_valid = 1'b0;
   logic [127:0] src0_data = '0, src1_data = '0;
   logic         src0_ready, src1_ready;
   logic [31:0]  m_tdata;
   logic         m_tvalid, m_tlast, m_tid, busy;
   logic         m_tready = 1'b1;

   // {m_tvalid, m_tlast, m_tid, busy, src0_ready, src1_ready}
   logic [5:0]   stat;
   assign stat = {m_tvalid, m_tlast, m_tid, busy, src0_ready, src1_ready};

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] BLK_A = 128'h0F0E0D0C0B0A09080706050403020100;
   localparam logic [127:0] BLK_B = 128'h1F1E1D1C1B1A19181716151413121110;
   logic [31:0] WA [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
   logic [31:0] WB [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};

   aes_out_block_scheduler #(.NWORDS(4), .WORD_W(32)) dut (
      .clk(clk), .resetn(resetn), .clear(clear),
      .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(src0_ready),
      .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .m_tid(m_tid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      #2;
      checks++;
      if (stat !== 6'b000000) begin
         errors++; $display("FAIL reset_stat: got %b exp %b", stat, 6'b000000);
      end
      checks++;
      if (m_tdata !== 32'h0) begin
         errors++; $display("FAIL reset_tdata: got %h exp %h", m_tdata, 32'h0);
      end
      @(negedge clk); resetn = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk); src0_valid = 1'b1; src0_data = BLK_A; #1;
      checks++;
      if (stat !== 6'b000010) begin
         errors++; $display("FAIL single_hs: got %b exp %b", stat, 6'b000010);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); src0_valid = 1'b0; #1;
         checks++;
         if (stat !== {1'b1, (i == 3), 1'b0, 1'b1, 2'b00}) begin
            errors++; $display("FAIL single_stat%0d: got %b exp %b", i, stat, {1'b1, (i == 3), 1'b0, 1'b1, 2'b00});
         end
         checks++;
         if (m_tdata !== WA[i]) begin
            errors++; $display("FAIL single_word%0d: got %h exp %h", i, m_tdata, WA[i]);
         end
      end
      @(negedge clk); #1;
      checks++;
      if (stat !== 6'b000000) begin
         errors++; $display("FAIL single_idle: got %b exp %b", stat, 6'b000000);
      end
   endtask

   task automatic test_contention();
      logic g, prev;
      @(negedge clk); resetn = 1'b0; #1; resetn = 1'b1;
      src0_valid = 1'b1; src0_data = BLK_A;
      src1_valid = 1'b1; src1_data = BLK_B;
      prev = 1'b0;
      for (int b = 0; b < 6; b++) begin
         g = (b % 2 == 1);
         if (b != 0) @(negedge clk);
         #1;
         checks++;
         if (stat !== {1'b0, 1'b0, prev, 1'b0, !g, g}) begin
            errors++; $display("FAIL rr_grant%0d: got %b exp %b", b, stat, {1'b0, 1'b0, prev, 1'b0, !g, g});
         end
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (b == 5) begin src0_valid = 1'b0; src1_valid = 1'b0; end
            #1;
            checks++;
            if (stat !== {1'b1, (i == 3), g, 1'b1, 2'b00}) begin
               errors++; $display("FAIL rr_drain%0d_%0d: got %b exp %b", b, i, stat, {1'b1, (i == 3), g, 1'b1, 2'b00});
            end
            checks++;
            if (m_tdata !== (g ? WB[i] : WA[i])) begin
               errors++; $display("FAIL rr_word%0d_%0d: got %h exp %h", b, i, m_tdata, (g ? WB[i] : WA[i]));
            end
         end
         prev = g;
      end
      @(negedge clk); #1;
      checks++;
      if (stat !== 6'b001000) begin
         errors++; $display("FAIL rr_idle: got %b exp %b", stat, 6'b001000);
      end
   endtask

   task automatic test_backpressure();
      logic       rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int         widx [7] = '{0, 1, 1, 1, 1, 2, 3};
      @(negedge clk); src0_valid = 1'b1; src0_data = BLK_A; #1;
      checks++;
      if (src0_ready !== 1'b1) begin
         errors++; $display("FAIL bp_hs: got %b exp %b", src0_ready, 1'b1);
      end
      for (int c = 0; c < 7; c++) begin
         @(negedge clk); src0_valid = 1'b0; m_tready = rdy[c]; #1;
         checks++;
         if (m_tvalid !== 1'b1 || m_tdata !== WA[widx[c]] || m_tlast !== (widx[c] == 3)) begin
            errors++; $display("FAIL bp_cycle%0d: got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                               c, m_tvalid, m_tdata, m_tlast, WA[widx[c]], (widx[c] == 3));
         end
      end
      @(negedge clk); m_tready = 1'b1; #1;
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_end: got v=%b busy=%b exp v=0 busy=0", m_tvalid, busy);
      end
   endtask

   task automatic test_wait_in_drain();
      @(negedge clk); src0_valid = 1'b1; src0_data = BLK_A; #1;
      checks++;
      if (stat !== 6'b000010) begin
         errors++; $display("FAIL wd_hs0: got %b exp %b", stat, 6'b000010);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); src0_valid = 1'b0; src1_valid = 1'b1; src1_data = BLK_B; #1;
         checks++;
         if (src1_ready !== 1'b0 || m_tdata !== WA[i]) begin
            errors++; $display("FAIL wd_drain%0d: got rdy1=%b d=%h exp rdy1=0 d=%h", i, src1_ready, m_tdata, WA[i]);
         end
      end
      @(negedge clk); #1;
      checks++;
      if (stat !== 6'b000001) begin
         errors++; $display("FAIL wd_hs1: got %b exp %b", stat, 6'b000001);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); src1_valid = 1'b0; #1;
         checks++;
         if (stat !== {1'b1, (i == 3), 1'b1, 1'b1, 2'b00} || m_tdata !== WB[i]) begin
            errors++; $display("FAIL wd_src1_%0d: got %b %h exp %b %h", i, stat, m_tdata, {1'b1, (i == 3), 1'b1, 1'b1, 2'b00}, WB[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_clear();
      @(negedge clk); src0_valid = 1'b1; src0_data = BLK_A; #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); src0_valid = 1'b0; src1_valid = 1'b1; src1_data = BLK_B;
         if (i == 2) clear = 1'b1;
         #1;
         checks++;
         if (m_tdata !== WA[i] || src1_ready !== 1'b0) begin
            errors++; $display("FAIL clr_pre%0d: got d=%h rdy1=%b exp d=%h rdy1=0", i, m_tdata, src1_ready, WA[i]);
         end
      end
      @(negedge clk); clear = 1'b0; #1;
      checks++;
      if (stat !== 6'b000001) begin
         errors++; $display("FAIL clr_after: got %b exp %b", stat, 6'b000001);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); src1_valid = 1'b0; #1;
         checks++;
         if (stat !== {1'b1, (i == 3), 1'b1, 1'b1, 2'b00} || m_tdata !== WB[i]) begin
            errors++; $display("FAIL clr_src1_%0d: got %b %h exp %b %h", i, stat, m_tdata, {1'b1, (i == 3), 1'b1, 1'b1, 2'b00}, WB[i]);
         end
      end
      // clear in IDLE must suppress a handshake
      @(negedge clk); src0_valid = 1'b1; clear = 1'b1; #1;
      checks++;
      if (src0_ready !== 1'b0) begin
         errors++; $display("FAIL clr_idle_rdy: got %b exp %b", src0_ready, 1'b0);
      end
      @(negedge clk); src0_valid = 1'b0; clear = 1'b0; #1;
      checks++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
         errors++; $display("FAIL clr_idle_busy: got busy=%b v=%b exp 0 0", busy, m_tvalid);
      end
   endtask

   task automatic test_reset_mid_drain();
      @(negedge clk); src1_valid = 1'b1; src1_data = BLK_B; #1;
      @(negedge clk); src1_valid = 1'b0; #1;
      checks++;
      if (stat !== 6'b101100 || m_tdata !== WB[0]) begin
         errors++; $display("FAIL rst_pre: got %b %h exp %b %h", stat, m_tdata, 6'b101100, WB[0]);
      end
      @(negedge clk); #2; resetn = 1'b0; #1;
      checks++;
      if (stat !== 6'b000000 || m_tdata !== 32'h0) begin
         errors++; $display("FAIL rst_async: got %b %h exp %b %h", stat, m_tdata, 6'b000000, 32'h0);
      end
      @(negedge clk); resetn = 1'b1;
      src0_valid = 1'b1; src0_data = BLK_A; src1_valid = 1'b1; src1_data = BLK_B; #1;
      checks++;
      if (stat !== 6'b000010) begin
         errors++; $display("FAIL rst_grant: got %b exp %b", stat, 6'b000010);
      end
      @(negedge clk); src0_valid = 1'b0; src1_valid = 1'b0; #1;
      checks++;
      if (stat !== 6'b100100 || m_tdata !== WA[0]) begin
         errors++; $display("FAIL rst_word0: got %b %h exp %b %h", stat, m_tdata, 6'b100100, WA[0]);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_wait_in_drain();
      test_clear();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
